// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, default widths and divide clamp for the timer prescaler
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {PERIODIC, ONESHOT} mode_t;

  localparam int unsigned DEF_PRE_W = 32;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_DIV_W = 5;

  function automatic int unsigned clamp_div(input int unsigned d, input int unsigned lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing a one-cycle tick every 2^div enabled cycles
module tick_gen
  import timer_pkg::*;
#(
  parameter int unsigned PRE_W = DEF_PRE_W,
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] mask;
  int unsigned      div_c;

  // mask selects the low div bits; the tick fires when they are all ones
  always_comb begin
    div_c = clamp_div(32'(div), PRE_W);
    mask  = '0;
    for (int unsigned i = 0; i < PRE_W; i++) begin
      mask[i] = (i < div_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
    end else if (run && clk_en) begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign tick = clk_en & run & (&(pre_cnt | ~mask));

endmodule

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - compare timer driven by a power-of-two prescaler tick
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRE_W = DEF_PRE_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] compare,
  input  logic             irq_clr,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             match,
  output logic             irq,
  output logic             wave
);

  state_t state_q, state_d;
  logic   clear;
  logic   hit;

  tick_gen #(.PRE_W(PRE_W), .DIV_W(DIV_W)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .run    (running),
    .clear  (clear),
    .div    (div),
    .tick   (tick)
  );

  assign running = (state_q == RUN);
  // a start or stop in the same cycle as the terminal tick preempts the match
  assign hit = running && tick && (count == compare) && !stop && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          clear = 1'b1;
        end else if (hit && mode_t'(mode) == ONESHOT) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      match <= 1'b0;
      irq   <= 1'b0;
      wave  <= 1'b0;
    end else begin
      match <= hit;
      if (hit)          irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      if (hit)          wave <= ~wave;
      if (clear) begin
        count <= '0;
      end else if (hit) begin
        if (mode_t'(mode) == PERIODIC) count <= '0;
      end else if (running && tick && !stop) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_prescaler.sv
// tb/tb_timer_prescaler.sv - self-checking bench for timer_prescaler
module tb_timer_prescaler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  div = '0;
  logic [15:0] compare = '0;
  logic        irq_clr = 1'b0;
  logic        tick;
  logic [15:0] count;
  logic        running;
  logic        match;
  logic        irq;
  logic        wave;

  int errors = 0;
  int checks = 0;

  timer_prescaler dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .div     (div),
    .compare (compare),
    .irq_clr (irq_clr),
    .tick    (tick),
    .count   (count),
    .running (running),
    .match   (match),
    .irq     (irq),
    .wave    (wave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks += 6;
    if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    if (match !== 1'b0) begin errors++; $display("FAIL reset_match got=%b exp=0", match); end
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    if (wave !== 1'b0) begin errors++; $display("FAIL reset_wave got=%b exp=0", wave); end
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_periodic();
    do_reset();
    div = 5'd0; compare = 16'd3; mode = 1'b0; clk_en = 1'b1;
    do_start();
    for (int e = 1; e <= 12; e++) begin
      step();
      checks += 3;
      if (match !== (e % 4 == 0)) begin errors++; $display("FAIL periodic_match edge=%0d got=%b", e, match); end
      if (count !== 16'(e % 4)) begin errors++; $display("FAIL periodic_count edge=%0d got=%0d exp=%0d", e, count, e % 4); end
      if (irq !== (e >= 4)) begin errors++; $display("FAIL periodic_irq edge=%0d got=%b", e, irq); end
      if (e % 4 == 0) begin
        checks++;
        if (wave !== 1'((e / 4) % 2)) begin errors++; $display("FAIL periodic_wave edge=%0d got=%b exp=%0d", e, wave, (e / 4) % 2); end
      end
    end
  endtask

  task automatic test_div();
    do_reset();
    div = 5'd2; compare = 16'd1; mode = 1'b0; clk_en = 1'b1;
    do_start();
    for (int e = 1; e <= 16; e++) begin
      checks++;
      if (tick !== (e % 4 == 0)) begin errors++; $display("FAIL div_tick cycle_before_edge=%0d got=%b", e, tick); end
      step();
      checks += 2;
      if (count !== 16'((e / 4) % 2)) begin errors++; $display("FAIL div_count edge=%0d got=%0d exp=%0d", e, count, (e / 4) % 2); end
      if (match !== (e % 8 == 0)) begin errors++; $display("FAIL div_match edge=%0d got=%b", e, match); end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    div = 5'd0; compare = 16'd2; mode = 1'b1; clk_en = 1'b1;
    do_start();
    for (int e = 1; e <= 6; e++) begin
      step();
      checks += 3;
      if (match !== (e == 3)) begin errors++; $display("FAIL oneshot_match edge=%0d got=%b", e, match); end
      if (count !== 16'(e < 3 ? e : 2)) begin errors++; $display("FAIL oneshot_count edge=%0d got=%0d", e, count); end
      if (running !== (e < 3)) begin errors++; $display("FAIL oneshot_running edge=%0d got=%b", e, running); end
    end
    do_start();
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (match !== (e == 3)) begin errors++; $display("FAIL oneshot_restart_match edge=%0d got=%b", e, match); end
    end
    mode = 1'b0;
  endtask

  task automatic test_clk_en();
    int k;
    do_reset();
    div = 5'd0; compare = 16'd3; mode = 1'b0; clk_en = 1'b1;
    do_start();
    k = 0;
    for (int c = 1; c <= 24; c++) begin
      clk_en = c[0];
      #1;
      checks++;
      if (tick !== clk_en) begin errors++; $display("FAIL clken_tick cycle=%0d got=%b exp=%b", c, tick, clk_en); end
      step();
      if (clk_en) k++;
      checks += 2;
      if (match !== (clk_en && k % 4 == 0)) begin errors++; $display("FAIL clken_match cycle=%0d got=%b", c, match); end
      if (count !== 16'(k % 4)) begin errors++; $display("FAIL clken_count cycle=%0d got=%0d exp=%0d", c, count, k % 4); end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_start_stop_irq();
    do_reset();
    div = 5'd0; compare = 16'd1; mode = 1'b0; clk_en = 1'b1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks += 2;
    if (running !== 1'b0) begin errors++; $display("FAIL startstop_running got=%b exp=0", running); end
    step();
    if (count !== 16'd0) begin errors++; $display("FAIL startstop_count got=%0d exp=0", count); end
    do_start();
    step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    checks += 2;
    if (match !== 1'b1) begin errors++; $display("FAIL irqclr_match got=%b exp=1", match); end
    if (irq !== 1'b1) begin errors++; $display("FAIL irqclr_same_cycle got=%b exp=1", irq); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irqclr_alone got=%b exp=0", irq); end
  endtask

  task automatic test_async_reset();
    do_reset();
    div = 5'd0; compare = 16'd10; mode = 1'b0; clk_en = 1'b1;
    do_start();
    for (int e = 0; e < 5; e++) step();
    checks++;
    if (count !== 16'd5) begin errors++; $display("FAIL areset_precount got=%0d exp=5", count); end
    rst = 1'b1;
    #2;
    checks += 4;
    if (count !== 16'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", count); end
    if (irq !== 1'b0) begin errors++; $display("FAIL areset_irq got=%b exp=0", irq); end
    if (wave !== 1'b0) begin errors++; $display("FAIL areset_wave got=%b exp=0", wave); end
    if (running !== 1'b0) begin errors++; $display("FAIL areset_running got=%b exp=0", running); end
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (match !== 1'b0 || running !== 1'b0) begin
        errors++; $display("FAIL areset_idle cycle=%0d match=%b running=%b exp=0/0", e, match, running);
      end
    end
  endtask

  // Model: the k-th enabled running cycle is a tick when k is a multiple of
  // 2^div; every (compare+1)-th tick is a match.
  task automatic test_random();
    int k, p, c, nm;
    bit en, exp_tick, exp_m;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      div = 5'($urandom_range(0, 3));
      compare = 16'($urandom_range(0, 4));
      mode = 1'b0; clk_en = 1'b1;
      p = 1 << div;
      c = int'(compare) + 1;
      do_start();
      k = 0; nm = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        en = ($urandom_range(0, 3) != 0);
        clk_en = en;
        #1;
        exp_tick = en && ((k + 1) % p == 0);
        checks++;
        if (tick !== exp_tick) begin errors++; $display("FAIL rand_tick it=%0d cyc=%0d got=%b exp=%b", it, cyc, tick, exp_tick); end
        step();
        if (en) k++;
        exp_m = en && (k % (p * c) == 0);
        if (exp_m) nm++;
        checks += 4;
        if (match !== exp_m) begin errors++; $display("FAIL rand_match it=%0d cyc=%0d got=%b exp=%b", it, cyc, match, exp_m); end
        if (count !== 16'((k / p) % c)) begin errors++; $display("FAIL rand_count it=%0d cyc=%0d got=%0d exp=%0d", it, cyc, count, (k / p) % c); end
        if (wave !== 1'(nm % 2)) begin errors++; $display("FAIL rand_wave it=%0d cyc=%0d got=%b exp=%0d", it, cyc, wave, nm % 2); end
        if (irq !== (nm > 0)) begin errors++; $display("FAIL rand_irq it=%0d cyc=%0d got=%b exp=%b", it, cyc, irq, nm > 0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_div();
    test_oneshot();
    test_clk_en();
    test_start_stop_irq();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
